// File: rtl/m2vbsr_if.sv
// Stream-word input and custom-instruction port of the m2vbsr bitstream reader.
interface m2vbsr_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CSEL_WIDTH = 3
);
  logic [DATA_WIDTH-1:0] s_data;
  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] custom_adata;
  logic [DATA_WIDTH-1:0] custom_bdata;
  logic [CSEL_WIDTH-1:0] custom_select;
  logic                  custom_start;
  logic                  custom_enable;
  logic [DATA_WIDTH-1:0] custom_result;
  logic                  custom_done;

  modport slave (
    input  s_data, s_valid, custom_adata, custom_bdata, custom_select,
           custom_start, custom_enable,
    output s_ready, custom_result, custom_done
  );

  modport master (
    output s_data, s_valid, custom_adata, custom_bdata, custom_select,
           custom_start, custom_enable,
    input  s_ready, custom_result, custom_done
  );
endinterface

// File: rtl/m2vbsr.sv
// MPEG-2 bitstream reader: 32-bit left-justified bit buffer fed by 16-bit words,
// executing show/get/skip/align/start-code/position commands for the processor.
//   state | meaning
//   IDLE  | waiting for custom_start
//   WAIT  | waiting for enough buffered bits, then execute
//   ALIGN | discard bits up to the next byte boundary
//   SCAN  | byte-wise search for the 0x000001 start-code prefix
//   DONE  | done pulse with the registered result
module m2vbsr #(
  parameter int DATA_WIDTH = 16,
  parameter int CSEL_WIDTH = 3
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     softreset,
  m2vbsr_if.slave  bus
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_WAIT  = 3'd1;
  localparam logic [2:0] ST_ALIGN = 3'd2;
  localparam logic [2:0] ST_SCAN  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  localparam logic [CSEL_WIDTH-1:0] CMD_SHOW   = CSEL_WIDTH'(0);
  localparam logic [CSEL_WIDTH-1:0] CMD_GET    = CSEL_WIDTH'(1);
  localparam logic [CSEL_WIDTH-1:0] CMD_SKIP   = CSEL_WIDTH'(2);
  localparam logic [CSEL_WIDTH-1:0] CMD_ALIGN  = CSEL_WIDTH'(3);
  localparam logic [CSEL_WIDTH-1:0] CMD_NEXTSC = CSEL_WIDTH'(4);
  localparam logic [CSEL_WIDTH-1:0] CMD_POS    = CSEL_WIDTH'(5);

  logic [31:0]           sbuf_q, sbuf_d;
  logic [5:0]            fill_q, fill_d, fill_after;
  logic [15:0]           pos_q;
  logic [2:0]            state_q, state_d;
  logic [CSEL_WIDTH-1:0] cmd_q, cmd_d;
  logic [4:0]            n_q, n_d, n_in;
  logic [DATA_WIDTH-1:0] result_q, result_d, show_val;
  logic                  done_q, done_d;
  logic [5:0]            consume;
  logic [2:0]            align_bits;
  logic                  load;
  logic                  unused_bits;

  assign unused_bits = ^{bus.custom_adata, bus.custom_bdata[DATA_WIDTH-1:5]};

  assign n_in       = (bus.custom_bdata[4:0] > 5'd16) ? 5'd16 : bus.custom_bdata[4:0];
  assign show_val   = (n_q == 5'd0) ? 16'h0000 : (sbuf_q[31:16] >> (5'd16 - n_q));
  assign align_bits = 3'd0 - pos_q[2:0];

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    n_d      = n_q;
    consume  = 6'd0;
    result_d = '0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.custom_start) begin
          state_d = ST_WAIT;
          cmd_d   = bus.custom_select;
          n_d     = n_in;
        end
      end
      ST_WAIT: begin
        if (!bus.custom_enable) begin
          state_d = ST_IDLE;
        end else begin
          case (cmd_q)
            CMD_SHOW, CMD_GET, CMD_SKIP: begin
              if (fill_q >= {1'b0, n_q}) begin
                state_d  = ST_DONE;
                done_d   = 1'b1;
                result_d = (cmd_q == CMD_SKIP) ? 16'h0000 : show_val;
                consume  = (cmd_q == CMD_SHOW) ? 6'd0 : {1'b0, n_q};
              end
            end
            CMD_ALIGN, CMD_NEXTSC: state_d = ST_ALIGN;
            CMD_POS: begin
              state_d  = ST_DONE;
              done_d   = 1'b1;
              result_d = pos_q;
            end
            default: begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          endcase
        end
      end
      ST_ALIGN: begin
        if (!bus.custom_enable) begin
          state_d = ST_IDLE;
        end else if (fill_q >= {3'b000, align_bits}) begin
          consume = {3'b000, align_bits};
          if (cmd_q == CMD_ALIGN) begin
            state_d  = ST_DONE;
            done_d   = 1'b1;
            result_d = {13'h0000, align_bits};
          end else begin
            state_d = ST_SCAN;
          end
        end
      end
      ST_SCAN: begin
        if (!bus.custom_enable) begin
          state_d = ST_IDLE;
        end else if (fill_q >= 6'd24) begin
          // After the prefix, the start-code value is fetched as an ordinary GET 8.
          if (sbuf_q[31:8] == 24'h000001) begin
            consume = 6'd24;
            cmd_d   = CMD_GET;
            n_d     = 5'd8;
            state_d = ST_WAIT;
          end else begin
            consume = 6'd8;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign fill_after  = fill_q - consume;
  assign bus.s_ready = ~reset & ~softreset & (fill_after <= 6'd16);
  assign load        = bus.s_valid & bus.s_ready;
  assign sbuf_d      = (sbuf_q << consume) |
                       (load ? ({bus.s_data, 16'h0000} >> fill_after) : 32'h0);
  assign fill_d      = fill_after + (load ? 6'd16 : 6'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sbuf_q   <= '0;
      fill_q   <= '0;
      pos_q    <= '0;
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else if (softreset) begin
      sbuf_q   <= '0;
      fill_q   <= '0;
      pos_q    <= '0;
      state_q  <= ST_IDLE;
      cmd_q    <= '0;
      n_q      <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      sbuf_q   <= sbuf_d;
      fill_q   <= fill_d;
      pos_q    <= pos_q + {10'h000, consume};
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      n_q      <= n_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Gating with enable keeps a late-dropped enable from ever showing a done.
  assign bus.custom_done   = done_q & bus.custom_enable;
  assign bus.custom_result = bus.custom_done ? result_q : '0;

endmodule

// File: doc/m2vbsr.md
# m2vbsr

Bitstream reader serving as the custom-instruction unit on the decode processor's `custom_*` port. It buffers 16-bit MPEG-2 video stream words from an upstream word source and executes bit-level commands for the processor: show bits, get bits, skip bits, byte-align, start-code search and position read. Each command is a start/enable/done transaction, and results are returned right-aligned on `custom_result`.

## Interface
- `DATA_WIDTH`, 16: processor data width and stream word width; the design supports only 16.
- `CSEL_WIDTH`, 3: width of the command select field.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `softreset`  in  1: synchronous flush, active-high.
- `s_data`  in  16: stream word; the MSB is the first bit in stream order.
- `s_valid`  in  1: `s_data` is valid.
- `s_ready`  out  1: the block accepts `s_data` this cycle.
- `custom_adata`  in  16: unused operand; it is ignored.
- `custom_bdata`  in  16: bit count n is taken from `[4:0]`.
- `custom_select`  in  3: command code.
- `custom_start`  in  1: one-cycle pulse in the first cycle of a command.
- `custom_enable`  in  1: held high from start until the cycle of done, inclusive.
- `custom_result`  out  16: command result; valid only while `custom_done` is high.
- `custom_done`  out  1: one-cycle completion pulse.

## Operation
- **Bit buffer**
  - 32-bit left-justified shift buffer `buf` with fill count `fill` (0..32).
  - `s_ready = ~reset & (fill_next_before_load <= 16)`. A word is accepted when `s_valid & s_ready`.
  - The accepted word is placed at bit position `[31-f:16-f]`, where f is the fill after this cycle's consume.
  - Consume and load in the same cycle are legal: `fill' = fill - c + 16`.
- **Bit count n**
  - n = `custom_bdata[4:0]`.
  - n=0 gives result 0 and no consume.
  - n>16 is clamped to 16.
- **Commands**
  - 0 SHOW: result = `buf[31:32-n]` right-aligned with the upper bits zero; no consume.
  - 1 GET: same result as SHOW, then consume n bits.
  - 2 SKIP: consume n bits; result 0.
  - 3 ALIGN: consume `pos[2:0]` complement bits to reach the next byte boundary (0 bits if already aligned); result = number of bits discarded (0..7).
  - 4 NEXTSC: perform ALIGN, then scan byte by byte.
    - While `fill>=24` and `buf[31:8] != 24'h000001`, consume 8 bits per cycle.
    - On a match, consume 24 bits, then perform GET 8.
    - Result = `{8'h00, start_code_value}`.
  - 5 POS: result = `pos`, the count of consumed bits modulo 2^16; completes in 1 cycle.
  - 6, 7 reserved: result 0; complete in 1 cycle.
- **`pos` counter**: 16 bits, incremented by every consume, wraps from 0xFFFF to 0x0000.
- **FSM states**: IDLE, WAIT, ALIGN, SCAN, DONE.
  - IDLE → WAIT on `custom_start` (command and n are latched).
  - WAIT → DONE when `fill >= n` for SHOW/GET/SKIP. POS and reserved commands go to DONE directly. ALIGN and NEXTSC go to ALIGN.
  - ALIGN → DONE (command 3) or SCAN (command 4) once enough bits are buffered.
  - SCAN → WAIT with an internal GET 8 after a match.
  - DONE → IDLE: `custom_done` pulses and the registered result is driven.
- **Robustness**
  - `custom_start` outside IDLE is ignored.
  - `custom_enable` falling before done aborts the command to IDLE with no done.
  - `custom_done` is never asserted while `custom_enable` is low.
- **Reset / softreset**
  - Both clear `fill`, `pos`, the FSM (to IDLE), `custom_done` and `custom_result`. Any command in flight is aborted without a done.
  - While either is asserted, no word is accepted.

## Timing
- Reset values: `custom_done`=0, `custom_result`=0x0000, `s_ready`=0 while `reset` is high, then 1 (fill=0).
- Start at cycle T with sufficient bits → `custom_done` at T+2 (one WAIT cycle, then DONE); result and consume are registered.
- Insufficient bits: the block waits in WAIT indefinitely. Done follows 2 cycles after the word that makes `fill >= n` is accepted.
- NEXTSC with the code already aligned and buffered: done at T+5.
- The result is held only during the done cycle; afterwards it returns to 0.

## Test plan
- **GET across a word boundary**: after reset, feed 0xA5C3 and 0x0F00; then GET 4 → 0x000A at T+2, GET 16 → 0x5C30, POS → 0x0014.
- **SHOW does not consume**: feed 0x8001; SHOW 1 → 0x0001, then SHOW 1 again → 0x0001, then GET 16 → 0x8001; `s_ready` is high throughout.
- **Starvation**: with `fill`=0, issue GET 8; `custom_done` stays 0 for 20 cycles with `s_valid`=0. Feed 0xFFxx → done 2 cycles later with result 0x00FF.
- **ALIGN then NEXTSC**: feed 0x1234, 0x0000, 0x01B3; GET 3, then NEXTSC → result 0x00B3 and POS = 0x0030.
- **softreset mid-command**: start GET 16 with `fill`=8 and pulse softreset → no `custom_done`; `fill`=0; POS → 0x0000.
- **`pos` wrap and n clamp**: skip 16 bits 4096 times, then POS → 0x0000. GET with `bdata`=31 behaves as GET 16.
